mem_arbiter: RTL and testbench

Sequencer and arbiter for the single-port 16-word data RAM. Two requesters share it: the instruction-fetch port (read only) and the LDR/STR data port driven by the memory control path. The block issues one RAM access at a time with fixed cycle timing, returns read data and write acknowledges, flags out-of-range addresses, and bounds fetch starvation under back-to-back LDR/STR traffic.

---
 rtl/mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port data-RAM sequencer: arbitrates fetch vs LDR/STR, issues one access
// at a time, returns data/acks with fixed latency and bounds fetch starvation.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int ADDR_BITS    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_rw,
  input  logic [15:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [15:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_ERR
  } state_t;

  localparam logic [3:0]  LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [15:0] HI_MASK = ~((16'd1 << ADDR_BITS) - 16'd1);

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        port_dm_q, port_dm_d;
  logic        if_gnt_q, if_gnt_d, if_valid_q, if_valid_d, if_err_q, if_err_d;
  logic        dm_gnt_q, dm_gnt_d, dm_valid_q, dm_valid_d, dm_err_q, dm_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic        ram_en_q, ram_en_d, ram_rw_q, ram_rw_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        busy_q, busy_d;

  logic        pick_dm;
  logic [15:0] acc_addr;
  logic        acc_wr;
  logic        acc_oor;

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    port_dm_d   = port_dm_q;
    if_gnt_d    = 1'b0;
    if_valid_d  = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_gnt_d    = 1'b0;
    dm_valid_d  = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = dm_rdata_q;
    ram_en_d    = 1'b0;
    ram_rw_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    // Data port wins contention until fetch has been passed over LIMIT times.
    pick_dm  = dm_req && !(if_req && streak_q == LIMIT);
    acc_addr = pick_dm ? dm_addr : if_addr;
    acc_wr   = pick_dm && dm_rw;
    acc_oor  = |(acc_addr & HI_MASK);

    unique case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          port_dm_d = pick_dm;
          if_gnt_d  = !pick_dm;
          dm_gnt_d  = pick_dm;
          if (pick_dm && if_req)
            streak_d = (streak_q >= LIMIT) ? LIMIT : streak_q + 4'd1;
          else
            streak_d = 4'd0;
          if (acc_oor) begin
            state_d = S_ERR;
          end else if (acc_wr) begin
            state_d     = S_WR_ISSUE;
            ram_en_d    = 1'b1;
            ram_rw_d    = 1'b1;
            ram_addr_d  = acc_addr;
            ram_wdata_d = dm_wdata;
          end else begin
            state_d    = S_RD_ISSUE;
            ram_en_d   = 1'b1;
            ram_addr_d = acc_addr;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        state_d = S_IDLE;
        if (port_dm_q) begin
          dm_valid_d = 1'b1;
          dm_rdata_d = ram_rdata;
        end else begin
          if_valid_d = 1'b1;
          if_rdata_d = ram_rdata;
        end
      end
      S_WR_ISSUE: begin
        state_d    = S_IDLE;
        dm_valid_d = 1'b1;
      end
      S_ERR: begin
        state_d = S_IDLE;
        if (port_dm_q) begin
          dm_valid_d = 1'b1;
          dm_err_d   = 1'b1;
          dm_rdata_d = 32'd0;
        end else begin
          if_valid_d = 1'b1;
          if_err_d   = 1'b1;
          if_rdata_d = 32'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      streak_q    <= 4'd0;
      port_dm_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      dm_gnt_q    <= 1'b0;
      dm_valid_q  <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= 32'd0;
      ram_en_q    <= 1'b0;
      ram_rw_q    <= 1'b0;
      ram_addr_q  <= 16'd0;
      ram_wdata_q <= 32'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      port_dm_q   <= port_dm_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_gnt_q    <= dm_gnt_d;
      dm_valid_q  <= dm_valid_d;
      dm_err_q    <= dm_err_d;
      dm_rdata_q  <= dm_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_rw_q    <= ram_rw_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign dm_gnt    = dm_gnt_q;
  assign dm_valid  = dm_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_err    = dm_err_q;
  assign ram_en    = ram_en_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: per-access timeline model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_mem_arbiter;
  localparam int LIMIT = 3;
  localparam int AB    = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_rw = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        if_gnt, if_valid, if_err, dm_gnt, dm_valid, dm_err;
  logic [31:0] if_rdata, dm_rdata;
  logic        ram_en, ram_rw, busy;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM fixture: synchronous read, data valid the cycle after the strobe
  logic [31:0] mem [16] = '{5: 32'hDEADBEEF, default: 32'h0};
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_rw) mem[ram_addr[3:0]] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr[3:0]];
    end
  end

  typedef struct packed {
    logic        if_gnt, if_valid;
    logic [31:0] if_rdata;
    logic        if_err, dm_gnt, dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_err, ram_en, ram_rw;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        busy;
  } obs_t;

  // Model: each accepted access expands into a fixed list of per-cycle outputs.
  obs_t        sched[$];
  obs_t        cur = '0, exp_o = '0, act, base, e0, e1, e2;
  logic [31:0] ref_mem [16] = '{5: 32'hDEADBEEF, default: 32'h0};
  int          streak = 0;
  bit          model_on = 0;
  bit          take_dm, wr, bad;
  logic [15:0] a;

  always @(negedge clk) begin
    act = {if_gnt, if_valid, if_rdata, if_err, dm_gnt, dm_valid, dm_rdata,
           dm_err, ram_en, ram_rw, ram_addr, ram_wdata, busy};
    if (model_on) begin
      checks++;
      if (act !== exp_o) begin
        errors++;
        $display("FAIL model t=%0t act %h exp %h", $time, act, exp_o);
      end
    end
    if (rst) begin
      sched.delete();
      cur = '0; streak = 0; exp_o = '0;
    end else begin
      if (sched.size() == 0 && (if_req || dm_req)) begin
        take_dm = dm_req && !(if_req && streak == LIMIT);
        if (take_dm && if_req) streak = (streak + 1 > LIMIT) ? LIMIT : streak + 1;
        else streak = 0;
        a   = take_dm ? dm_addr : if_addr;
        wr  = take_dm && dm_rw;
        bad = int'(a) >= (1 << AB);
        base = cur;
        base.if_gnt = 0; base.if_valid = 0; base.if_err = 0;
        base.dm_gnt = 0; base.dm_valid = 0; base.dm_err = 0;
        base.ram_en = 0; base.ram_rw = 0; base.busy = 0;
        e0 = base; e0.busy = 1;
        if (take_dm) e0.dm_gnt = 1; else e0.if_gnt = 1;
        if (bad) begin
          e1 = base;
          if (take_dm) begin e1.dm_valid = 1; e1.dm_err = 1; e1.dm_rdata = 0; end
          else begin e1.if_valid = 1; e1.if_err = 1; e1.if_rdata = 0; end
          sched.push_back(e0); sched.push_back(e1);
        end else if (wr) begin
          e0.ram_en = 1; e0.ram_rw = 1; e0.ram_addr = a; e0.ram_wdata = dm_wdata;
          ref_mem[a[3:0]] = dm_wdata;
          e1 = base; e1.ram_addr = a; e1.ram_wdata = dm_wdata; e1.dm_valid = 1;
          sched.push_back(e0); sched.push_back(e1);
        end else begin
          e0.ram_en = 1; e0.ram_addr = a;
          e1 = base; e1.ram_addr = a; e1.busy = 1;
          e2 = base; e2.ram_addr = a;
          if (take_dm) begin e2.dm_valid = 1; e2.dm_rdata = ref_mem[a[3:0]]; end
          else begin e2.if_valid = 1; e2.if_rdata = ref_mem[a[3:0]]; end
          sched.push_back(e0); sched.push_back(e1); sched.push_back(e2);
        end
      end
      if (sched.size() > 0) exp_o = sched.pop_front();
      else begin
        exp_o = cur;
        exp_o.if_gnt = 0; exp_o.if_valid = 0; exp_o.if_err = 0;
        exp_o.dm_gnt = 0; exp_o.dm_valid = 0; exp_o.dm_err = 0;
        exp_o.ram_en = 0; exp_o.ram_rw = 0; exp_o.busy = 0;
      end
      cur = exp_o;
    end
    model_on = 1;
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s act %h exp %h", name, act_v, exp_v);
    end
  endtask

  string order;

  initial begin
    repeat (2) step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_if_rdata", if_rdata, 0);
    rst = 0;

    // fetch read of RAM[5]
    if_req = 1; if_addr = 16'd5;
    step();
    chk("f_gnt", 32'(if_gnt), 1); chk("f_en", 32'(ram_en), 1);
    chk("f_addr", 32'(ram_addr), 5); chk("f_busy0", 32'(busy), 1);
    if_req = 0;
    step();
    chk("f_busy1", 32'(busy), 1); chk("f_en1", 32'(ram_en), 0);
    step();
    chk("f_valid", 32'(if_valid), 1); chk("f_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_busy2", 32'(busy), 0);

    // STR 3 then LDR 3
    dm_req = 1; dm_rw = 1; dm_addr = 16'd3; dm_wdata = 32'h12345678;
    step();
    chk("w_gnt", 32'(dm_gnt), 1); chk("w_en", 32'(ram_en), 1); chk("w_rw", 32'(ram_rw), 1);
    dm_rw = 0;
    step();
    chk("w_valid", 32'(dm_valid), 1);
    step();
    chk("r_gnt", 32'(dm_gnt), 1); chk("r_rw", 32'(ram_rw), 0);
    dm_req = 0;
    step(); step();
    chk("r_valid", 32'(dm_valid), 1); chk("r_rdata", dm_rdata, 32'h12345678);

    // continuous contention
    if_req = 1; if_addr = 16'd1; dm_req = 1; dm_rw = 0; dm_addr = 16'd2;
    order = "";
    for (int i = 0; i < 24; i++) begin
      step();
      if (dm_gnt) order = {order, "d"};
      if (if_gnt) order = {order, "i"};
    end
    checks++;
    if (order != "dddidddi") begin
      errors++;
      $display("FAIL grant_order act %s exp dddidddi", order);
    end
    if_req = 0; dm_req = 0;

    // out-of-range LDR
    dm_req = 1; dm_rw = 0; dm_addr = 16'h0010;
    step();
    chk("e_gnt", 32'(dm_gnt), 1); chk("e_en", 32'(ram_en), 0);
    dm_req = 0;
    step();
    chk("e_valid", 32'(dm_valid), 1); chk("e_err", 32'(dm_err), 1); chk("e_rdata", dm_rdata, 0);

    // out-of-range STR must not touch RAM[3]
    dm_req = 1; dm_rw = 1; dm_addr = 16'h0013; dm_wdata = 32'hFFFFFFFF;
    step();
    chk("ew_en", 32'(ram_en), 0);
    dm_rw = 0; dm_addr = 16'd3;
    step();
    chk("ew_err", 32'(dm_err), 1);
    step();
    dm_req = 0;
    step(); step();
    chk("ew_keep", dm_rdata, 32'h12345678); chk("ew_err0", 32'(dm_err), 0);

    // top legal address
    dm_req = 1; dm_rw = 1; dm_addr = 16'd15; dm_wdata = 32'hA5A5A5A5;
    step();
    chk("b_addr", 32'(ram_addr), 15);
    dm_rw = 0;
    step(); step();
    dm_req = 0;
    step(); step();
    chk("b_rdata", dm_rdata, 32'hA5A5A5A5);

    // fetch out of range
    if_req = 1; if_addr = 16'h8000;
    step();
    chk("fe_gnt", 32'(if_gnt), 1);
    if_req = 0;
    step();
    chk("fe_err", 32'(if_err), 1); chk("fe_rdata", if_rdata, 0);

    // reset during a read
    dm_req = 1; dm_rw = 0; dm_addr = 16'd5;
    step();
    chk("x_gnt", 32'(dm_gnt), 1);
    rst = 1; dm_req = 0;
    step();
    chk("x_busy", 32'(busy), 0); chk("x_addr", 32'(ram_addr), 0);
    chk("x_dm_rdata", dm_rdata, 0); chk("x_wdata", ram_wdata, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("x_novalid", 32'(dm_valid), 0);
    end
    if_req = 1; if_addr = 16'd5;
    step();
    chk("x2_gnt", 32'(if_gnt), 1);
    if_req = 0;
    step(); step();
    chk("x2_valid", 32'(if_valid), 1); chk("x2_rdata", if_rdata, 32'hDEADBEEF);

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
